// File: rtl/nibble_add_sched.sv
// nibble_add_sched: performs WIDTH-bit additions nibble-serially on one shared external
// 4-bit adder slice, round-robin arbitrating between two requesters.
module nibble_add_sched #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             id_q, id_d;
    logic             last_gnt_q, last_gnt_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             winner;
    logic [KW+1:0]    sh;
    logic             last_nib;
    logic [WIDTH-1:0] acc_merge;

    // Round-robin pick: on a tie the requester that was not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // Bit offset of the current nibble and the accumulator with that nibble replaced.
    always_comb begin
        sh        = {k_q, 2'b00};
        last_nib  = (k_q == KW'(NIB - 1));
        acc_merge = (acc_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(add_sum) << sh);
    end

    // Drive the shared slice only while running; carry-in of nibble 0 is the requester's cin.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == StRun) begin
            add_a   = 4'(a_q >> sh);
            add_b   = 4'(b_q >> sh);
            add_cin = (k_q == '0) ? cin_q : carry_q;
        end
    end

    // Next-state logic for the controller and its registered outputs.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        acc_d      = acc_q;
        id_d       = id_q;
        last_gnt_d = last_gnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    a_d        = winner ? a1 : a0;
                    b_d        = winner ? b1 : b0;
                    cin_d      = winner ? cin1 : cin0;
                    id_d       = winner;
                    last_gnt_d = winner;
                    k_d        = '0;
                    ack0_d     = ~winner;
                    ack1_d     = winner;
                    state_d    = StRun;
                end
            end
            StRun: begin
                acc_d   = acc_merge;
                carry_d = add_cout;
                if (last_nib) begin
                    // Publish the result on the same edge the last nibble lands.
                    state_d   = StDone;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    sum_d     = acc_merge;
                    cout_d    = add_cout;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            acc_q      <= '0;
            id_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            acc_q      <= acc_d;
            id_q       <= id_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule
